// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : audio_i2s_tx
// Description : I2S audio transmitter fed by a 4-entry stereo PCM FIFO.
//               A clk divider produces the bit clock; each frame carries one
//               {left,right} pair, MSB first, one bclk behind word-select.
// Ports       : clk        - single clock, rising edge
//               rst        - synchronous active-high reset
//               pcm_stb    - one-cycle push strobe for pcm_left/pcm_right
//               pcm_left   - signed 16-bit left sample
//               pcm_right  - signed 16-bit right sample
//               clr_flags  - clears the sticky overflow/underflow flags
//               i2s_bclk   - bit clock
//               i2s_lrclk  - word select (0 = left, 1 = right)
//               i2s_sdata  - serial data
//               fifo_level - stereo entries held, 0..4
//               overflow   - sticky: a pushed pair was dropped
//               underflow  - sticky: an empty frame went out after priming
// Revision    : 1.0 - initial release
// ============================================================================
module audio_i2s_tx #(
  parameter int HALF_DIV  = 25,
  parameter int SLOT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcm_stb,
  input  logic [15:0] pcm_left,
  input  logic [15:0] pcm_right,
  input  logic        clr_flags,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic [2:0]  fifo_level,
  output logic        overflow,
  output logic        underflow
);

  localparam int DW = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);

  localparam logic [DW-1:0] c_DIV_LAST   = DW'(HALF_DIV - 1);
  localparam logic [BW-1:0] c_B_LAST     = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] c_B_LDATA    = BW'(16);
  localparam logic [BW-1:0] c_B_RSLOT    = BW'(SLOT_BITS);
  localparam logic [BW-1:0] c_B_RDATA_HI = BW'(SLOT_BITS + 15);
  localparam logic [BW-1:0] c_B_WS_RISE  = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] c_B_WS_FALL  = BW'(2 * SLOT_BITS - 2);

  // Registered state
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic [BW-1:0] b_q, b_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic [31:0]   frame_q, frame_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          primed_q, primed_d;
  logic [31:0]   mem_q [0:3];
  logic [31:0]   mem_d [0:3];

  // Combinational helpers
  logic          w_div_wrap;
  logic          w_fall;
  logic          w_pop_pt;
  logic          w_empty;
  logic          w_full;
  logic          w_do_pop;
  logic          w_do_push;
  logic [BW-1:0] w_roff;
  logic [15:0]   w_left;
  logic [15:0]   w_right;
  logic          w_lr_next;
  logic          w_sd_next;

  // --------------------------------------------------------------------------
  // Bit clock, bit index and serial output
  // --------------------------------------------------------------------------
  always_comb begin
    w_div_wrap = (div_cnt_q == c_DIV_LAST);
    // bclk is about to go 1->0: this is the only cycle the serial side moves
    w_fall     = w_div_wrap && bclk_q;

    div_cnt_d  = w_div_wrap ? '0 : div_cnt_q + DW'(1);
    bclk_d     = w_div_wrap ? ~bclk_q : bclk_q;

    b_d = b_q;
    if (w_fall) begin
      b_d = (b_q == c_B_LAST) ? '0 : b_q + BW'(1);
    end

    // Frame register is swapped while the last (padding) bit is going out,
    // so the new word is first seen at the following b = 0.
    w_pop_pt = w_fall && (b_d == c_B_LAST);

    w_left  = frame_q[31:16];
    w_right = frame_q[15:0];
    w_roff  = b_d - c_B_RSLOT;

    // Bit positions 0..15 inside a slot map to sample bits 15..0, i.e. the
    // inverted low nibble of the slot offset.
    w_sd_next = 1'b0;
    if (b_d < c_B_LDATA) begin
      w_sd_next = w_left[~b_d[3:0]];
    end else if ((b_d >= c_B_RSLOT) && (b_d <= c_B_RDATA_HI)) begin
      w_sd_next = w_right[~w_roff[3:0]];
    end

    // Word select leads the slot by one bit (standard I2S delay)
    w_lr_next = (b_d >= c_B_WS_RISE) && (b_d <= c_B_WS_FALL);

    lrclk_d = w_fall ? w_lr_next : lrclk_q;
    sdata_d = w_fall ? w_sd_next : sdata_q;
  end

  // --------------------------------------------------------------------------
  // FIFO, frame register and sticky flags
  // --------------------------------------------------------------------------
  always_comb begin
    w_empty   = (count_q == 3'd0);
    w_full    = (count_q == 3'd4);
    w_do_pop  = w_pop_pt && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    w_do_push = pcm_stb && (!w_full || w_do_pop);

    mem_d = mem_q;
    if (w_do_push) begin
      mem_d[wr_ptr_q] = {pcm_left, pcm_right};
    end

    wr_ptr_d = w_do_push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = w_do_pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;

    unique case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    frame_d = frame_q;
    if (w_pop_pt) begin
      frame_d = w_empty ? 32'd0 : mem_q[rd_ptr_q];
    end

    primed_d = primed_q | w_do_pop;

    // A new event in the same cycle as clr_flags keeps the flag set
    overflow_d = overflow_q;
    if (pcm_stb && w_full && !w_do_pop) begin
      overflow_d = 1'b1;
    end else if (clr_flags) begin
      overflow_d = 1'b0;
    end

    underflow_d = underflow_q;
    if (w_pop_pt && w_empty && primed_q) begin
      underflow_d = 1'b1;
    end else if (clr_flags) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      b_q         <= '0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      frame_q     <= 32'd0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      b_q         <= b_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_q     <= frame_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      primed_q    <= primed_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;
  assign fifo_level = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_i2s_tx
// Description : Testbench for audio_i2s_tx. Instance A (default parameters)
//               is compared every cycle against a time-based behavioural
//               model and directed scenarios; instance B (HALF_DIV=2,
//               SLOT_BITS=17) is monitored for bit-clock/frame timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_tx;

  localparam int HD    = 25;
  localparam int SB    = 20;
  localparam int BITC  = 2 * HD;
  localparam int FRAME = BITC * 2 * SB;
  localparam int HD2   = 2;
  localparam int SB2   = 17;
  localparam int TMO   = 30000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A
  logic        rst = 1'b1;
  logic        pcm_stb = 1'b0;
  logic [15:0] pcm_left = '0;
  logic [15:0] pcm_right = '0;
  logic        clr_flags = 1'b0;
  logic        bclk_a, lr_a, sd_a, ovf_a, udf_a;
  logic [2:0]  lvl_a;

  // Instance B
  logic        rst_b = 1'b1;
  logic        stb_b = 1'b0;
  logic [15:0] left_b = '0;
  logic [15:0] right_b = '0;
  logic        bclk_b, lr_b, sd_b, ovf_b, udf_b;
  logic [2:0]  lvl_b;

  audio_i2s_tx #(.HALF_DIV(HD), .SLOT_BITS(SB)) u_dut_a (
    .clk(clk), .rst(rst), .pcm_stb(pcm_stb), .pcm_left(pcm_left),
    .pcm_right(pcm_right), .clr_flags(clr_flags), .i2s_bclk(bclk_a),
    .i2s_lrclk(lr_a), .i2s_sdata(sd_a), .fifo_level(lvl_a),
    .overflow(ovf_a), .underflow(udf_a)
  );

  audio_i2s_tx #(.HALF_DIV(HD2), .SLOT_BITS(SB2)) u_dut_b (
    .clk(clk), .rst(rst_b), .pcm_stb(stb_b), .pcm_left(left_b),
    .pcm_right(right_b), .clr_flags(1'b0), .i2s_bclk(bclk_b),
    .i2s_lrclk(lr_b), .i2s_sdata(sd_b), .fifo_level(lvl_b),
    .overflow(ovf_b), .underflow(udf_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model of instance A: everything follows from the number of
  // clk edges since reset (m_tm) plus a queue of pending stereo words.
  // --------------------------------------------------------------------------
  int          m_tm = 0;
  logic [31:0] m_q[$];
  logic [31:0] m_cur = '0;
  bit          m_ovf = 0, m_udf = 0, m_primed = 0, m_pop = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_tm = 0;
      m_q.delete();
      m_cur = '0;
      m_ovf = 0;
      m_udf = 0;
      m_primed = 0;
    end else begin
      m_tm = m_tm + 1;
      m_pop = (m_tm % BITC == 0) && ((m_tm / BITC) % (2 * SB) == 2 * SB - 1);
      if (clr_flags) begin
        m_ovf = 0;
        m_udf = 0;
      end
      if (m_pop) begin
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_primed = 1;
        end else begin
          m_cur = '0;
          if (m_primed) m_udf = 1;
        end
      end
      if (pcm_stb) begin
        if (m_q.size() < 4) m_q.push_back({pcm_left, pcm_right});
        else m_ovf = 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-cycle compare (A vs model) and timing monitor for B
  // --------------------------------------------------------------------------
  bit         chk_a = 0;
  int         bb;
  logic       e_sd, e_lr, e_bclk;
  logic [7:0] e_vec;

  int   cyc_b = 0;
  bit   b_live = 0;
  int   last_rise_b = -1;
  int   last_lr_b = -1;
  logic pb = 1'b0, plr = 1'b0, psd = 1'b0;

  always @(posedge clk) begin
    if (rst_b) begin
      cyc_b  = 0;
      b_live = 1;
    end else begin
      cyc_b = cyc_b + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_a) begin
      bb     = (m_tm / BITC) % (2 * SB);
      e_bclk = ((m_tm / HD) % 2) == 1;
      e_lr   = (bb >= SB - 1) && (bb <= 2 * SB - 2);
      e_sd   = 1'b0;
      if (bb < 16) e_sd = m_cur[31 - bb];
      else if (bb >= SB && bb < SB + 16) e_sd = m_cur[15 - (bb - SB)];
      e_vec = {e_bclk, e_lr, e_sd, 3'(m_q.size()), m_ovf, m_udf};
      check("outputs_vs_model", {bclk_a, lr_a, sd_a, lvl_a, ovf_a, udf_a}, e_vec);
    end

    if (b_live && !rst_b) begin
      if ((lr_b !== plr) || (sd_b !== psd)) begin
        check("b_change_only_on_fall", {pb, bclk_b}, 2'b10);
      end
      if (bclk_b && !pb) begin
        if (last_rise_b < 0) check("b_first_rise", cyc_b, HD2);
        else check("b_bclk_period", cyc_b - last_rise_b, 2 * HD2);
        last_rise_b = cyc_b;
      end
      if (lr_b && !plr) begin
        if (last_lr_b >= 0) check("b_frame_len", cyc_b - last_lr_b, 2 * 2 * HD2 * SB2);
        last_lr_b = cyc_b;
      end
    end
    pb  = bclk_b;
    plr = lr_b;
    psd = sd_b;
  end

  // Instance B stimulus: one new random pair per frame keeps sdata moving
  initial begin
    repeat (4) @(negedge clk);
    rst_b = 1'b0;
    forever begin
      repeat (2 * 2 * HD2 * SB2) @(negedge clk);
      left_b  = 16'($urandom);
      right_b = 16'($urandom);
      stb_b   = 1'b1;
      @(negedge clk);
      stb_b   = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Directed scenarios on instance A
  // --------------------------------------------------------------------------
  task automatic do_reset();
    rst = 1'b1;
    pcm_stb = 1'b0;
    clr_flags = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    pcm_left  = l;
    pcm_right = r;
    pcm_stb   = 1'b1;
    @(negedge clk);
    pcm_stb   = 1'b0;
  endtask

  task automatic wait_tm(input int target);
    int n = 0;
    while (m_tm < target && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      total++;
      bad++;
      $display("FAIL wait_tm timeout: reached=%0d required=%0d", m_tm, target);
    end
  endtask

  task automatic wait_frame_start();
    int n = 0;
    while (!((m_tm % FRAME == 0) && (m_tm > 0)) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) begin
      total++;
      bad++;
      $display("FAIL frame_start timeout: tm=%0d required=multiple of %0d", m_tm, FRAME);
    end
  endtask

  // sd/lr bit 39-i holds bit index i of the frame
  task automatic capture(output logic [39:0] sd, output logic [39:0] lr);
    wait_frame_start();
    for (int i = 0; i < 2 * SB; i++) begin
      sd[39 - i] = sd_a;
      lr[39 - i] = lr_a;
      repeat (BITC) @(negedge clk);
    end
  endtask

  logic [39:0] cap_sd, cap_lr;
  logic [15:0] pl [0:4];
  logic [15:0] pr [0:4];

  initial begin
    @(negedge clk);
    chk_a = 1;

    // Single sample
    do_reset();
    check("reset_outputs", {bclk_a, lr_a, sd_a, lvl_a, ovf_a, udf_a}, 8'h00);
    push(16'h8001, 16'h7FFE);
    check("single_level", lvl_a, 3'd1);
    wait_frame_start();
    check("single_underflow", udf_a, 1'b0);
    capture(cap_sd, cap_lr);
    check("single_left", cap_sd[39:24], 16'b1000000000000001);
    check("single_lpad", cap_sd[23:20], 4'h0);
    check("single_right", cap_sd[19:4], 16'b0111111111111110);
    check("single_rpad", cap_sd[3:0], 4'h0);
    check("single_lrclk", cap_lr, 40'h00001FFFFE);

    // Overflow
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pl[i] = 16'hA5A0 + 16'(i);
      pr[i] = 16'h3C30 + 16'(i);
      push(pl[i], pr[i]);
    end
    check("ovf_level", lvl_a, 3'd4);
    check("ovf_flag", ovf_a, 1'b1);
    for (int k = 0; k < 4; k++) begin
      capture(cap_sd, cap_lr);
      check("ovf_order", {cap_sd[39:24], cap_sd[19:4]}, {pl[k], pr[k]});
    end
    capture(cap_sd, cap_lr);
    check("ovf_dropped", cap_sd, 40'h0);

    // Underflow
    do_reset();
    push(16'h1234, 16'hABCD);
    wait_tm(1960);
    check("udf_first_pop", udf_a, 1'b0);
    capture(cap_sd, cap_lr);
    check("udf_data", {cap_sd[39:24], cap_sd[19:4]}, 32'h1234ABCD);
    check("udf_second_pop", udf_a, 1'b1);
    capture(cap_sd, cap_lr);
    check("udf_empty_frame", cap_sd, 40'h0);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("udf_cleared", udf_a, 1'b0);

    // Push coinciding with pop on a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pl[i] = 16'hC000 + 16'(i);
      pr[i] = 16'h0300 + 16'(i);
      push(pl[i], pr[i]);
    end
    pl[4] = 16'h7E57;
    pr[4] = 16'h8BAD;
    wait_tm(2 * SB * BITC - BITC - 1);
    push(pl[4], pr[4]);
    check("simul_level", lvl_a, 3'd4);
    check("simul_ovf", ovf_a, 1'b0);
    for (int k = 0; k < 5; k++) begin
      capture(cap_sd, cap_lr);
      check("simul_order", {cap_sd[39:24], cap_sd[19:4]}, {pl[k], pr[k]});
    end

    // Reset in the middle of a frame
    do_reset();
    for (int i = 0; i < 3; i++) push(16'hFFFF, 16'hFFFF);
    wait_tm(FRAME + 7 * BITC);
    check("midrst_before", {sd_a, lvl_a}, 4'b1010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outputs", {bclk_a, lr_a, sd_a, lvl_a, ovf_a, udf_a}, 8'h00);
    capture(cap_sd, cap_lr);
    check("midrst_frame", cap_sd, 40'h0);
    check("midrst_udf", udf_a, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
